// File: rtl/dm_bus_pkg.sv
// Shared types and helpers for the debug-module system-bus host.
package dm_bus_pkg;

    localparam int unsigned DefaultBusWidth = 32;

    typedef enum logic [2:0] {
        SbErrNone    = 3'd0,
        SbErrTimeout = 3'd1,
        SbErrBus     = 3'd2,
        SbErrAlign   = 3'd3,
        SbErrSize    = 3'd4,
        SbErrOther   = 3'd7
    } sberr_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    // Byte-enable pattern for an access of 2^size bytes starting at lane 0.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size);
        logic [7:0] mask;
        case (size)
            3'd0:    mask = 8'h01;
            3'd1:    mask = 8'h03;
            3'd2:    mask = 8'h0f;
            3'd3:    mask = 8'hff;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_bus_lane.sv
// Byte-lane steering: aligns write data and byte enables to the address offset
// and extracts right-aligned, zero-extended read data.
module dm_bus_lane
    import dm_bus_pkg::*;
#(
    parameter int unsigned BusWidth = DefaultBusWidth,
    localparam int unsigned BeW     = BusWidth / 8,
    localparam int unsigned OffW    = $clog2(BeW)
) (
    input  logic [OffW-1:0]     off_i,
    input  logic [2:0]          size_i,
    input  logic [BusWidth-1:0] wdata_i,
    input  logic [BusWidth-1:0] rdata_i,
    output logic [BeW-1:0]      be_o,
    output logic [BusWidth-1:0] wdata_o,
    output logic [BusWidth-1:0] rdata_o
);

    logic [BeW-1:0]      size_be;
    logic [BusWidth-1:0] size_bits;

    always_comb begin
        size_be = BeW'(size_to_mask(size_i));
        for (int i = 0; i < int'(BeW); i++) begin
            size_bits[8*i +: 8] = {8{size_be[i]}};
        end
    end

    assign be_o    = size_be << off_i;
    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign rdata_o = (rdata_i >> {off_i, 3'b000}) & size_bits;

endmodule

// File: rtl/dm_bus_host.sv
// System-bus host engine: splits debug-module access commands into sized beats
// on a req/gnt/r_valid bus and records sticky error codes.
module dm_bus_host
    import dm_bus_pkg::*;
#(
    parameter int unsigned BusWidth      = DefaultBusWidth,
    parameter int unsigned MaxBurst      = 16,
    parameter int unsigned TimeoutCycles = 255,
    localparam int unsigned LenW         = $clog2(MaxBurst + 1),
    localparam int unsigned BeW          = BusWidth / 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [BusWidth-1:0] cmd_addr_i,
    input  logic [BusWidth-1:0] cmd_wdata_i,
    input  logic [2:0]          cmd_size_i,
    input  logic [LenW-1:0]     cmd_len_i,
    input  logic                cmd_autoinc_i,
    output logic                rsp_valid_o,
    output logic [BusWidth-1:0] rsp_rdata_o,
    output logic                done_o,
    output logic [BusWidth-1:0] next_addr_o,
    output logic                busy_o,
    output logic [2:0]          err_o,
    input  logic                err_clear_i,
    output logic                req_o,
    output logic                we_o,
    output logic [BusWidth-1:0] addr_o,
    output logic [BusWidth-1:0] wdata_o,
    output logic [BeW-1:0]      be_o,
    input  logic                gnt_i,
    input  logic                r_valid_i,
    input  logic [BusWidth-1:0] rdata_i,
    input  logic                r_err_i,
    input  logic                r_other_err_i
);

    localparam int unsigned OffW    = $clog2(BeW);
    localparam int unsigned MaxSize = $clog2(BeW);

    state_e              state_q, state_d;
    sberr_e              err_q, err_d;
    logic [BusWidth-1:0] addr_q, addr_d;
    logic [BusWidth-1:0] next_addr_q, next_addr_d;
    logic [BusWidth-1:0] wdata_q, wdata_d;
    logic [BusWidth-1:0] rdata_q, rdata_d;
    logic [2:0]          size_q, size_d;
    logic                we_q, we_d;
    logic                autoinc_q, autoinc_d;
    logic [LenW-1:0]     beats_q, beats_d;
    logic [31:0]         to_cnt_q, to_cnt_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [BeW-1:0]      lane_be;
    logic [BusWidth-1:0] lane_wdata, lane_rdata;
    logic [BusWidth-1:0] align_mask, incr;
    logic [LenW-1:0]     len_eff;
    logic                accept, size_bad, misaligned, timed_out;

    dm_bus_lane #(
        .BusWidth(BusWidth)
    ) u_lane (
        .off_i  (addr_q[OffW-1:0]),
        .size_i (size_q),
        .wdata_i(wdata_q),
        .rdata_i(rdata_i),
        .be_o   (lane_be),
        .wdata_o(lane_wdata),
        .rdata_o(lane_rdata)
    );

    assign cmd_ready_o = (state_q == StIdle) && (err_q == SbErrNone) && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign size_bad    = 32'(cmd_size_i) > MaxSize;
    assign align_mask  = (BusWidth'(1) << cmd_size_i) - BusWidth'(1);
    assign misaligned  = |(cmd_addr_i & align_mask);
    assign incr        = BusWidth'(1) << size_q;
    // Counter is compared before it increments, so the limit cycle itself counts.
    assign timed_out   = (TimeoutCycles != 0) && ((to_cnt_q + 32'd1) >= TimeoutCycles);

    always_comb begin
        if (cmd_len_i == '0) begin
            len_eff = LenW'(1);
        end else if (32'(cmd_len_i) > MaxBurst) begin
            len_eff = LenW'(MaxBurst);
        end else begin
            len_eff = cmd_len_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        size_d      = size_q;
        we_d        = we_q;
        autoinc_d   = autoinc_q;
        beats_d     = beats_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = 1'b0;

        // Any new error assigned below overrides this clear.
        if (err_clear_i) begin
            err_d = SbErrNone;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    size_d    = cmd_size_i;
                    we_d      = cmd_we_i;
                    autoinc_d = cmd_autoinc_i;
                    beats_d   = len_eff;
                    to_cnt_d  = '0;
                    if (size_bad) begin
                        err_d   = SbErrSize;
                        state_d = StDone;
                    end else if (misaligned) begin
                        err_d   = SbErrAlign;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (gnt_i) begin
                    state_d = StWait;
                end else if (timed_out) begin
                    err_d   = SbErrTimeout;
                    state_d = StDone;
                end
            end
            StWait: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (r_valid_i) begin
                    if (r_other_err_i) begin
                        err_d   = SbErrOther;
                        state_d = StDone;
                    end else if (r_err_i) begin
                        err_d   = SbErrBus;
                        state_d = StDone;
                    end else begin
                        rsp_valid_d = !we_q;
                        if (!we_q) begin
                            rdata_d = lane_rdata;
                        end
                        next_addr_d = addr_q + incr;
                        if (autoinc_q) begin
                            addr_d = addr_q + incr;
                        end
                        if (beats_q == LenW'(1)) begin
                            state_d = StDone;
                        end else begin
                            beats_d  = beats_q - LenW'(1);
                            to_cnt_d = '0;
                            state_d  = StReq;
                        end
                    end
                end else if (timed_out) begin
                    err_d   = SbErrTimeout;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            err_q       <= SbErrNone;
            addr_q      <= '0;
            next_addr_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            autoinc_q   <= 1'b0;
            beats_q     <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            size_q      <= size_d;
            we_q        <= we_d;
            autoinc_q   <= autoinc_d;
            beats_q     <= beats_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_o       = (state_q == StReq);
    assign we_o        = req_o && we_q;
    assign addr_o      = req_o ? addr_q : '0;
    assign wdata_o     = req_o ? lane_wdata : '0;
    assign be_o        = req_o ? lane_be : '0;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign next_addr_o = next_addr_q;

endmodule
